// File: rtl/rs_pkg.sv
// Shared constants, types and GF(2^8) helpers for the RS(18,16) encode path.
package rs_pkg;

    localparam int unsigned N            = 18;
    localparam int unsigned K            = 16;
    localparam int unsigned SYMBOL_WIDTH = 8;

    localparam logic [SYMBOL_WIDTH:0] PRIM_POLY = 9'h11D;

    typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

    localparam symbol_t G1 = 8'h06;
    localparam symbol_t G0 = 8'h08;

    typedef enum logic {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Multiply by alpha (x) and reduce modulo the primitive polynomial.
    function automatic symbol_t gf_xtime(input symbol_t a);
        symbol_t red;
        red = a[SYMBOL_WIDTH-1] ? PRIM_POLY[SYMBOL_WIDTH-1:0] : '0;
        return {a[SYMBOL_WIDTH-2:0], 1'b0} ^ red;
    endfunction

    // Shift-and-add GF multiply; folds to XOR trees when one operand is constant.
    function automatic symbol_t gf_mul(input symbol_t a, input symbol_t b);
        symbol_t acc;
        symbol_t sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < SYMBOL_WIDTH; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_const_mult.sv
// Combinational GF(2^8) multiply of a symbol by a compile-time constant.
module gf_const_mult
    import rs_pkg::*;
#(
    parameter symbol_t COEF = SYMBOL_WIDTH'(1)
) (
    input  logic [SYMBOL_WIDTH-1:0] a,
    output logic [SYMBOL_WIDTH-1:0] prod_c
);

    assign prod_c = gf_mul(a, COEF);

endmodule

// File: rtl/rs_encoder_serial.sv
// Serial systematic RS(18,16) encoder: 2-stage LFSR parity, codeword held until taken.
module rs_encoder_serial
    import rs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SYMBOL_WIDTH-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*SYMBOL_WIDTH-1:0] out_codeword,
    output logic                      err_last
);

    localparam int unsigned CNT_W = $clog2(K);
    localparam int unsigned IDX_W = $clog2(N);

    state_t               state;
    state_t               state_d;
    logic                 in_ready_d;
    logic                 out_valid_d;

    logic [CNT_W-1:0]     cnt;
    symbol_t              r1;
    symbol_t              r0;
    symbol_t              fb;
    symbol_t              fb_g1;
    symbol_t              fb_g0;
    symbol_t              r1_d;
    symbol_t              r0_d;
    logic                 xfer;
    logic                 last_sym;
    logic [IDX_W-1:0]     msg_idx;
    symbol_t              cw [N];

    assign xfer     = in_valid & in_ready;
    assign last_sym = (cnt == CNT_W'(K - 1));
    assign fb       = in_data ^ r1;
    assign r1_d     = r0 ^ fb_g1;
    assign r0_d     = fb_g0;
    // First symbol received is m[K-1], which lands in the top codeword slot.
    assign msg_idx  = IDX_W'(N - 1) - IDX_W'(cnt);

    gf_const_mult #(.COEF(G1)) u_mul_g1 (.a(fb), .prod_c(fb_g1));
    gf_const_mult #(.COEF(G0)) u_mul_g0 (.a(fb), .prod_c(fb_g0));

    // State register with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCEPT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ACCEPT:  if (xfer && last_sym) state_d = HOLD;
            HOLD:    if (out_ready)        state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    // Output decode of the upcoming state, captured by the state register
    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (state_d == HOLD) begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    // LFSR, symbol counter, codeword capture and framing check
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r1       <= '0;
            r0       <= '0;
            err_last <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                cw[i] <= '0;
            end
        end else begin
            err_last <= xfer & (in_last ^ last_sym);
            if (xfer) begin
                cw[msg_idx] <= in_data;
                if (last_sym) begin
                    cw[1] <= r1_d;
                    cw[0] <= r0_d;
                    cnt   <= '0;
                    r1    <= '0;
                    r0    <= '0;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    r1    <= r1_d;
                    r0    <= r0_d;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign out_codeword[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = cw[i];
    end

endmodule
